// File: rtl/sr_latch_exerciser.sv
// Self-checking driver for a gated SR latch. Walks the 8 {En,S,R} vectors,
// samples the latch Q through a 2-flop synchronizer, and compares it against
// a golden model of the latch. Reports busy/done/pass and a mismatch count.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, outputs quiet
// ST_DRIVE | current vector on En/S/R, waiting HOLD_CYCLES for Q to settle
// ST_CHECK | one cycle: sample q_sync, update the model, count a mismatch
// ST_DONE  | run finished, results held until the next start or reset

module sr_latch_exerciser #(
   parameter int HOLD_CYCLES = 4,
   parameter int LOOPS       = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       q_in,
   output logic       En,
   output logic       S,
   output logic       R,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [2:0] step
);

   localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [HOLD_W-1:0]   r_hold;
   logic [7:0]          r_loop;
   logic [2:0]          r_step;
   logic [7:0]          r_err;
   logic                r_q_meta;
   logic                r_q_sync;
   logic                r_exp;
   logic                r_known;

   logic                w_accept;
   logic                w_hold_tc;
   logic                w_last_step;
   logic                w_last_loop;
   logic                w_exp_nxt;
   logic                w_known_nxt;
   logic                w_mismatch;

   assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_hold_tc   = (r_hold == HOLD_W'(HOLD_CYCLES - 1));
   assign w_last_step = (r_step == 3'd7);
   assign w_last_loop = (r_loop == 8'(LOOPS - 1));

   // The vector is simply the step index, so the drive pins follow r_step.
   assign En        = r_step[2];
   assign S         = r_step[1];
   assign R         = r_step[0];
   assign step      = r_step;
   assign err_count = r_err;

   // Golden latch model: next (exp, known) for the vector currently driven.
   always_comb begin
      w_exp_nxt   = r_exp;
      w_known_nxt = r_known;
      if (r_step[2]) begin
         case (r_step[1:0])
            2'b01:   begin w_exp_nxt = 1'b0; w_known_nxt = 1'b1; end
            2'b10:   begin w_exp_nxt = 1'b1; w_known_nxt = 1'b1; end
            2'b11:   w_known_nxt = 1'b0;
            default: ;
         endcase
      end
   end

   // Compare against the model as it stands after this step's update.
   assign w_mismatch = w_known_nxt && (r_q_sync != w_exp_nxt);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic and status outputs.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      pass        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_DRIVE;
         end
         ST_DRIVE: begin
            busy = 1'b1;
            if (w_hold_tc) w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            busy = 1'b1;
            if (w_last_step && w_last_loop) w_state_nxt = ST_DONE;
            else                            w_state_nxt = ST_DRIVE;
         end
         ST_DONE: begin
            done = 1'b1;
            pass = (r_err == 8'd0);
            if (w_accept) w_state_nxt = ST_DRIVE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: synchronizer, counters, step/loop sequencing and the model.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q_meta <= 1'b0;
         r_q_sync <= 1'b0;
         r_hold   <= '0;
         r_loop   <= 8'd0;
         r_step   <= 3'd0;
         r_err    <= 8'd0;
         r_exp    <= 1'b0;
         r_known  <= 1'b0;
      end else begin
         r_q_meta <= q_in;
         r_q_sync <= r_q_meta;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  r_hold <= '0;
                  r_loop <= 8'd0;
                  r_step <= 3'd0;
                  r_err  <= 8'd0;
               end
            end
            ST_DRIVE: begin
               // Wraps harmlessly at terminal count; CHECK clears it.
               r_hold <= r_hold + 1'b1;
            end
            ST_CHECK: begin
               r_hold  <= '0;
               r_exp   <= w_exp_nxt;
               r_known <= w_known_nxt;
               if (w_mismatch && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
               if (!w_last_step) begin
                  r_step <= r_step + 3'd1;
               end else if (!w_last_loop) begin
                  r_step <= 3'd0;
                  r_loop <= r_loop + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_exerciser.sv
// Bench for sr_latch_exerciser: a behavioural gated SR latch feeds q_in (or a
// stuck-at value), expected run results go into a scoreboard when start is
// driven and are compared when done rises.

module tb_sr_latch_exerciser;

   localparam int HOLD = 4;
   localparam int LAT1 = 8 * 1 * (HOLD + 1);

   typedef struct {
      int err;
      int pass;
      int lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       q_in;
   logic       En, S, R, busy, done, pass;
   logic [7:0] err_count;
   logic [2:0] step;

   logic       start2 = 1'b0;
   logic       q_in2 = 1'b0;
   logic       En2, S2, R2, busy2, done2, pass2;
   logic [7:0] err_count2;
   logic [2:0] step2;

   int         n_cmp = 0;
   int         n_err = 0;
   int         q_mode = 0;
   logic       lq = 1'b0;

   exp_t       sb[$];
   exp_t       sb2[$];

   always #5 clk = ~clk;

   sr_latch_exerciser #(.HOLD_CYCLES(HOLD), .LOOPS(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_in),
      .En(En), .S(S), .R(R), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .step(step)
   );

   sr_latch_exerciser #(.HOLD_CYCLES(HOLD), .LOOPS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .q_in(q_in2),
      .En(En2), .S(S2), .R(R2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err_count2), .step(step2)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Behavioural gated SR latch; settles shortly after the drive pins move.
   always @(posedge clk) begin
      #1;
      if (En) begin
         if (S && !R)      lq = 1'b1;
         else if (R && !S) lq = 1'b0;
      end
   end

   assign q_in = (q_mode == 0) ? lq : (q_mode == 1) ? 1'b0 : 1'b1;

   // Monitor for dut: vector sequence, hold length, latency, run results.
   logic       busy_d = 1'b0;
   logic       done_d = 1'b0;
   logic [2:0] step_d = 3'd0;
   logic [2:0] exp_step = 3'd0;
   int         run_len = 0;
   int         busy_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_d   = 1'b0;
         done_d   = 1'b0;
         run_len  = 0;
         busy_cnt = 0;
      end else begin
         if (busy) begin
            if (!busy_d) begin
               exp_step = 3'd0;
               run_len  = 1;
               busy_cnt = 1;
            end else begin
               busy_cnt++;
               if (step != step_d) begin
                  chk("hold_len", run_len, HOLD + 1);
                  exp_step = exp_step + 3'd1;
                  run_len  = 1;
               end else begin
                  run_len++;
               end
            end
            chk("step", int'(step), int'(exp_step));
            chk("vector", int'({En, S, R}), int'(exp_step));
         end
         if (done && !done_d) begin
            chk("last_hold", run_len, HOLD + 1);
            chk("done_step", int'(step), 7);
            if (sb.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("err_count", int'(err_count), e.err);
               chk("pass", int'(pass), e.pass);
               chk("latency", busy_cnt, e.lat);
            end
         end
         busy_d = busy;
         done_d = done;
         step_d = step;
      end
   end

   // Monitor for dut2 (two loops).
   logic done2_d = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         done2_d = 1'b0;
      end else begin
         if (done2 && !done2_d) begin
            if (sb2.size() == 0) begin
               chk("sb2_empty", 1, 0);
            end else begin
               exp_t e;
               e = sb2.pop_front();
               chk("err_count2", int'(err_count2), e.err);
               chk("pass2", int'(pass2), e.pass);
            end
         end
         done2_d = done2;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int err, input int ps);
      exp_t e;
      e.err = err; e.pass = ps; e.lat = LAT1;
      sb.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done) begin seen = 1'b1; break; end
         tick();
      end
      chk("done_timeout", int'(seen), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      chk("reset_state", int'({En, S, R, busy, done, pass, err_count, step}), 0);
      rst_n = 1'b1;
      tick();
      chk("idle_quiet", int'({busy, done}), 0);

      // Healthy latch; extra start pulses while busy must not disturb timing.
      q_mode = 0;
      push(0, 1);
      pulse_start();
      chk("busy_rise", int'(busy), 1);
      repeat (7) tick();
      pulse_start();
      repeat (11) tick();
      pulse_start();
      wait_done(100);

      // Q stuck low: only step 6 (set) disagrees.
      q_mode = 1;
      push(1, 0);
      pulse_start();
      wait_done(100);

      // Q stuck high: only step 5 (reset) disagrees.
      q_mode = 2;
      push(1, 0);
      pulse_start();
      wait_done(100);

      // Reset during step 3, then a fresh clean run.
      q_mode = 0;
      pulse_start();
      for (int i = 0; i < 100; i++) begin
         if (step == 3'd3) break;
         tick();
      end
      chk("reach_step3", int'(step), 3);
      tick();
      rst_n = 1'b0;
      tick();
      chk("midrun_reset", int'({En, S, R, busy, done, pass, err_count, step}), 0);
      rst_n = 1'b1;
      tick();
      push(0, 1);
      pulse_start();
      wait_done(100);

      // start held high through DONE restarts immediately.
      push(0, 1);
      push(0, 1);
      start = 1'b1;
      tick();
      wait_done(100);
      tick();
      start = 1'b0;
      chk("restart_busy", int'({busy, done}), 2);
      wait_done(100);

      // Two loops with Q stuck low, then restart from DONE with err_count=2.
      begin
         exp_t e;
         e.err = 2; e.pass = 0; e.lat = 2 * LAT1;
         sb2.push_back(e);
      end
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done2) break;
         tick();
      end
      chk("done2", int'(done2), 1);
      tick();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      chk("restart2", int'({done2, busy2, err_count2, step2, En2, S2, R2}), 16'h0 | (1 << 14));

      tick();
      chk("sb_drained", sb.size(), 0);
      chk("sb2_drained", sb2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
